// File: rtl/key_io_responder_pkg.sv
// Shared definitions for the key I/O responder: bus addresses, KCTRL bit
// positions, debounce counter width and the register-select encoding.
package key_io_responder_pkg;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned DEB_CNT_W = 20;

  localparam logic [31:0] KEY_IO_ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] KEY_IO_ADDR_KCTRL = 32'hF000_0110;

  localparam int unsigned KCTRL_READY_BIT = 0;
  localparam int unsigned KCTRL_OVERRUN_BIT = 2;
  localparam int unsigned KCTRL_IE_BIT = 8;

  // Which register, if any, the current bus address selects.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_KDATA = 2'd1,
    SEL_KCTRL = 2'd2
  } reg_sel_e;

endpackage : key_io_responder_pkg

// File: rtl/key_io_responder_debouncer.sv
// key_debouncer: 2-flop synchronizer, per-vector stability counter and
// stable key state (pressed = 1). 'change' pulses in the cycle whose
// closing edge loads a new stable value.
module key_debouncer
  import key_io_responder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] stable,
  output logic                change
);

  localparam logic [DEB_CNT_W-1:0] CNT_LIMIT = DEB_CNT_W'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0]  meta_d, meta_q;
  logic [NUM_KEYS-1:0]  sync_d, sync_q;
  logic [NUM_KEYS-1:0]  stable_d, stable_q;
  logic [DEB_CNT_W-1:0] cnt_d, cnt_q;

  // Next-state logic: synchronizer shift, counter and stable-state commit.
  // The inversion sits in front of the first flop so that the cleared
  // synchronizer means "no key pressed" and matches the cleared stable
  // state; latency is the same as inverting after the second flop.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    meta_d   = ~key_n;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    change   = 1'b0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LIMIT) begin
        stable_d = sync_q;
        change   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : key_debouncer

// File: rtl/key_io_responder.sv
// key_io_responder: memory-mapped responder for four debounced board keys.
// KDATA returns the stable key state; KCTRL holds ready/overrun/ie.
// Optional build macro KEY_IO_IRQ_EN enables the ie bit and the registered
// interrupt irq = ie & ready; without it irq is 0 and ie reads as 0.
module key_io_responder
  import key_io_responder_pkg::*;
#(
  parameter int unsigned          DBITS           = 32,
  parameter logic [DBITS-1:0]     ADDR_KDATA      = DBITS'(KEY_IO_ADDR_KDATA),
  parameter logic [DBITS-1:0]     ADDR_KCTRL      = DBITS'(KEY_IO_ADDR_KCTRL),
  parameter int unsigned          DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [DBITS-1:0]    addr,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [DBITS-1:0]    data_in,
  output logic [DBITS-1:0]    data_out,
  output logic                hit,
  output logic                irq
);

  reg_sel_e            sel;
  logic [NUM_KEYS-1:0] stable;
  logic                change;
  logic                kdata_rd;
  logic                kctrl_wr;
  logic                ready_d, ready_q;
  logic                overrun_d, overrun_q;
  logic                ie;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (KEY),
    .stable (stable),
    .change (change)
  );

  // Address decode and combinational read mux (depends on addr only).
  always_comb begin
    sel      = SEL_NONE;
    data_out = '0;
    if (addr == ADDR_KDATA) begin
      sel      = SEL_KDATA;
      data_out = DBITS'(stable);
    end else if (addr == ADDR_KCTRL) begin
      sel                         = SEL_KCTRL;
      data_out[KCTRL_IE_BIT]      = ie;
      data_out[KCTRL_OVERRUN_BIT] = overrun_q;
      data_out[KCTRL_READY_BIT]   = ready_q;
    end
  end

  assign hit      = (sel != SEL_NONE);
  assign kdata_rd = rd_en && (sel == SEL_KDATA);
  assign kctrl_wr = wr_en && (sel == SEL_KCTRL);

  // Status update: a committing change wins over a KDATA read for ready,
  // and only a change the CPU has not yet consumed raises overrun.
  always_comb begin
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (kdata_rd) ready_d = 1'b0;
    if (change)   ready_d = 1'b1;
    if (kctrl_wr && !data_in[KCTRL_OVERRUN_BIT]) overrun_d = 1'b0;
    if (change && ready_q && !kdata_rd)          overrun_d = 1'b1;
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef KEY_IO_IRQ_EN
  logic ie_d, ie_q;
  logic irq_d, irq_q;

  // Interrupt enable loads from KCTRL writes; irq follows ie & ready by one edge.
  always_comb begin
    ie_d  = kctrl_wr ? data_in[KCTRL_IE_BIT] : ie_q;
    irq_d = ie_q & ready_q;
  end

  // Interrupt registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // Write-data bits outside the decoded fields are intentionally ignored.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

endmodule : key_io_responder

// File: tb/tb_key_io_responder.sv
// Directed self-checking bench for key_io_responder with DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_key_io_responder;

  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_OTHER = 32'h0000_0040;

`ifdef KEY_IO_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;

  key_io_responder #(
    .DBITS          (32),
    .ADDR_KDATA     (A_KDATA),
    .ADDR_KCTRL     (A_KCTRL),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .KEY     (key),
    .addr    (addr),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .data_in (data_in),
    .data_out(data_out),
    .hit     (hit),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational register peek (no side effects without rd_en).
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, data_out, exp);
  endtask

  task automatic kdata_read();
    addr  = A_KDATA;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic kctrl_write(input logic [31:0] d);
    addr    = A_KCTRL;
    data_in = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    key     = 4'hF;
    addr    = A_OTHER;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    data_in = '0;
    #1;

    // Reset state and decode.
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("other_hit", {31'd0, hit}, 32'd0);
    check("other_data", data_out, 32'd0);
    peek("reset_kctrl", A_KCTRL, 32'd0);
    check("kctrl_hit", {31'd0, hit}, 32'd1);
    peek("reset_kdata", A_KDATA, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // Press KEY[1]: ready appears on the 7th edge after the press.
    key = 4'hD;
    tick(6);
    peek("press1_ready_c6", A_KCTRL, 32'd0);
    tick(1);
    peek("press1_ready_c7", A_KCTRL, 32'd1);
    peek("press1_kdata", A_KDATA, 32'h2);
    check("kdata_hit", {31'd0, hit}, 32'd1);
    kdata_read();
    peek("press1_read_clr", A_KCTRL, 32'd0);
    tick(2);
    key = 4'hF;
    tick(7);
    peek("rel1_ready", A_KCTRL, 32'd1);
    peek("rel1_kdata", A_KDATA, 32'h0);
    kdata_read();
    peek("rel1_read_clr", A_KCTRL, 32'd0);

    // Access to an unmapped address has no effect.
    addr  = A_OTHER;
    rd_en = 1'b1;
    wr_en = 1'b1;
    data_in = 32'hFFFF_FFFF;
    tick(1);
    rd_en = 1'b0;
    wr_en = 1'b0;
    peek("other_noeffect", A_KCTRL, 32'd0);

    // Glitch on KEY[0] shorter than the debounce window.
    key = 4'hE;
    tick(3);
    key = 4'hF;
    tick(10);
    peek("glitch_kdata", A_KDATA, 32'h0);
    peek("glitch_ready", A_KCTRL, 32'd0);

    // Press and release KEY[0] without reading: overrun.
    key = 4'hE;
    tick(7);
    peek("press0_ready", A_KCTRL, 32'd1);
    tick(2);
    key = 4'hF;
    tick(7);
    peek("overrun_set", A_KCTRL, 32'h5);
    kctrl_write(32'h4);
    peek("overrun_wr1_keep", A_KCTRL, 32'h5);
    addr    = A_KDATA;
    data_in = 32'hF;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
    peek("kdata_wr_ignored", A_KDATA, 32'h0);
    kctrl_write(32'h0);
    peek("overrun_clr", A_KCTRL, 32'h1);
    kdata_read();
    peek("overrun_ready_clr", A_KCTRL, 32'h0);

    // KDATA read on the same edge a change commits.
    key = 4'hB;
    tick(6);
    kdata_read();
    peek("rd_commit_ready", A_KCTRL, 32'h1);
    peek("rd_commit_kdata", A_KDATA, 32'h4);
    kdata_read();
    key = 4'hF;
    tick(7);
    kdata_read();
    peek("rd_commit_done", A_KCTRL, 32'h0);

    // Interrupt enable and irq timing.
    kctrl_write(32'h100);
    peek("ie_readback", A_KCTRL, IRQ_BUILD ? 32'h100 : 32'h0);
    key = 4'h7;
    tick(7);
    peek("irq_ready", A_KCTRL, IRQ_BUILD ? 32'h101 : 32'h1);
    check("irq_before", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_rise", {31'd0, irq}, {31'd0, IRQ_BUILD});
    kdata_read();
    tick(1);
    check("irq_drop", {31'd0, irq}, 32'd0);
    key = 4'hF;
    tick(7);
    kdata_read();
    kctrl_write(32'h0);
    tick(2);
    check("irq_idle", {31'd0, irq}, 32'd0);

    // Reset during a pending release abandons it.
    key = 4'hD;
    tick(7);
    peek("pre_rst_kdata", A_KDATA, 32'h2);
    key = 4'hF;
    tick(4);
    reset_n = 1'b0;
    #1;
    peek("rst_kdata", A_KDATA, 32'h0);
    peek("rst_kctrl", A_KCTRL, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    peek("post_rst_kctrl", A_KCTRL, 32'h0);
    peek("post_rst_kdata", A_KDATA, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_io_responder

// File: doc/key_io_responder.md
KEY_IO_RESPONDER -- requirements
Module: key_io_responder

Interface
REQ-001 Parameter DBITS, default 32: data bus width.
REQ-002 Parameter ADDR_KDATA, default 32'hF0000010: key data register address.
REQ-003 Parameter ADDR_KCTRL, default 32'hF0000110: key control/status register address.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a key change; legal range 1..2^20-1.
REQ-005 Port list, one per line, SHALL be:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- KEY  in  4  raw board keys, active-low, asynchronous to clk
- addr  in  DBITS  processor bus address
- rd_en  in  1  processor read strobe, one cycle per access
- wr_en  in  1  processor write strobe
- data_in  in  DBITS  processor write data
- data_out  out  DBITS  read data; zero when no address hit
- hit  out  1  addr equals ADDR_KDATA or ADDR_KCTRL
- irq  out  1  interrupt request (see Configuration)

Function
REQ-006 KEY SHALL pass through a 2-flop synchronizer, then be inverted so pressed = 1 internally.
REQ-007 Debounce: the synchronized value differing from stable state SHALL increment a 20-bit counter; the counter SHALL clear whenever the values match.
REQ-008 When the counter reaches DEBOUNCE_CYCLES, stable state SHALL load the synchronized value on that edge, and the counter SHALL clear.
REQ-009 A stable-state change SHALL set KCTRL.ready (bit 0) on the same edge.
REQ-010 If ready is already 1 when a change commits and no KDATA read occurs that cycle, KCTRL.overrun (bit 2) SHALL set.
REQ-011 Read of KDATA: data_out = {zeros, stable[3:0]}, combinational from addr.
REQ-012 rd_en with addr==ADDR_KDATA SHALL clear ready on the next edge, unless a change commits on that same edge: then ready stays 1 and overrun is unchanged.
REQ-013 Read of KCTRL: data_out = {zeros, ie (bit 8), overrun (bit 2), 1'b0, ready (bit 0)}, no side effects.
REQ-014 Write to KCTRL: ready is read-only; writing 0 to bit 2 SHALL clear overrun, and writing 1 leaves it unchanged; bit 8 SHALL load ie.
REQ-015 Writes to KDATA SHALL be ignored, and accesses to other addresses SHALL have no effect.
REQ-016 Simultaneous rd_en and wr_en SHALL both take effect, as independent accesses to the same address.
REQ-017 Stable-state changes SHALL have latency 2 sync cycles + DEBOUNCE_CYCLES + 1 cycles from the KEY edge.

Reset
REQ-018 Asserting reset_n low SHALL immediately clear the synchronizer, stable state, counter, ready, overrun, ie and irq; data_out depends only on addr.
REQ-019 Reset mid-debounce SHALL abandon the pending change, and no ready SHALL result from it.

Configuration
REQ-020 Macro KEY_IO_IRQ_EN defined: irq = ie & ready, registered, asserting one cycle after ready rises with ie=1.
REQ-021 Macro KEY_IO_IRQ_EN undefined: irq tied 0, ie bit SHALL read 0, and writes to it SHALL be ignored.

Structure
REQ-022 Address constants, KCTRL bit positions and the counter width SHALL live in the shared IO package (IoDefs.vh).
REQ-023 Debounce SHALL be one sub-module, key_debouncer (sync + counter + stable state), instantiated once for the 4-bit vector.

Verification
REQ-024 All scenarios run with DEBOUNCE_CYCLES=4.
REQ-025 Press KEY[1] held 10 cycles -> ready=1 at cycle 7; KDATA reads 32'h2.
REQ-026 Glitch KEY[0] low for 3 cycles -> stable unchanged, ready stays 0.
REQ-027 Press KEY[0], no read, release KEY[0] -> KCTRL reads 32'h5; write KCTRL 32'h0 -> reads 32'h1.
REQ-028 KDATA read on the same edge a change commits -> ready remains 1, overrun 0.
REQ-029 With KEY_IO_IRQ_EN, write KCTRL 32'h100, press KEY[3] -> irq rises one cycle after ready; KDATA read drops irq the next cycle.
REQ-030 Assert reset_n mid-debounce -> all outputs and registers are 0 immediately, and no ready appears after release.
